// File: rtl/neopixel_rx.sv
// neopixel_rx: single-wire NeoPixel (WS2812/WS2811) receiver on the 20 MHz neoClk domain.
// Synchronizes the NRZ line, measures high times to decode 24-bit pixel words, and writes
// each completed word to a downstream FIFO through a dOut/wr_en/full_flg handshake.
// Latch gaps, pixels per frame, malformed bits and dropped words are reported.
// Optional feature macro: NEO_RX_FWD_EN builds a repeater on neo_fwd_out that strips the
// first pixel of every frame. Without it neo_fwd_out is tied low.

`default_nettype none

module neopixel_rx #(
    parameter int THRESH_CYC = 12,
    parameter int MIN_HI_CYC = 3,
    parameter int MAX_HI_CYC = 20,
    parameter int LATCH_CYC  = 1000
) (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic        mode,
    input  logic        neo_rx_in,
    input  logic        full_flg,
    input  logic        clr_flg,
    output logic [23:0] dOut,
    output logic        wr_en,
    output logic        latch_pulse,
    output logic [9:0]  pixel_cnt,
    output logic        err_flg,
    output logic        ovf_flg,
    output logic        neo_fwd_out
);

    localparam int              LO_W     = $clog2(LATCH_CYC + 1);
    localparam logic [LO_W-1:0] LATCH_L  = LO_W'(LATCH_CYC);
    localparam logic [LO_W-1:0] LO_ONE   = LO_W'(1);
    localparam logic [10:0]     THRESH_B = 11'(THRESH_CYC);
    localparam logic [10:0]     MIN_B    = 11'(MIN_HI_CYC);
    localparam logic [10:0]     MAX_B    = 11'(MAX_HI_CYC);
    localparam logic [10:0]     HI_SAT   = 11'h7FF;
    localparam logic [9:0]      PIX_SAT  = 10'h3FF;

    typedef enum logic [1:0] {
        WAIT_LATCH = 2'd0,
        IDLE       = 2'd1,
        HIGH       = 2'd2,
        LOW        = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            sync1;
    logic            sync2;
    logic            sync3;
    logic            line_rise;
    logic            line_fall;

    logic            mode_q;
    logic [10:0]     thresh_s;
    logic [10:0]     min_s;
    logic [10:0]     max_s;

    logic [10:0]     hi_cnt;
    logic [10:0]     hi_next;
    logic [LO_W-1:0] lo_cnt;
    logic [LO_W-1:0] lo_next;
    logic [4:0]      bit_cnt;
    logic [22:0]     word_sr;

    logic            ev_err;
    logic            ev_shift;
    logic            ev_latch;
    logic            bit_val;
    logic            word_done;
    logic            partial_err;

    assign line_rise = sync2 & ~sync3;
    assign line_fall = ~sync2 & sync3;

    // 400 kHz mode doubles every pulse-width limit; the latch gap stays fixed
    assign thresh_s = mode_q ? {THRESH_B[9:0], 1'b0} : THRESH_B;
    assign min_s    = mode_q ? {MIN_B[9:0], 1'b0}    : MIN_B;
    assign max_s    = mode_q ? {MAX_B[9:0], 1'b0}    : MAX_B;

    // hi_next is the high time including the current clock, so at the falling edge
    // it equals the number of clocks the synchronized line was high
    assign hi_next = (hi_cnt == HI_SAT) ? hi_cnt : hi_cnt + 11'd1;
    assign lo_next = (lo_cnt == LATCH_L) ? lo_cnt : lo_cnt + LO_ONE;

    assign bit_val     = (hi_next >= thresh_s);
    assign word_done   = ev_shift && (bit_cnt == 5'd23);
    assign partial_err = ev_latch && (bit_cnt != 5'd0);

    // Two-flop synchronizer plus a third stage that supplies the previous level for edge detection
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= neo_rx_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // State register; reset lands in WAIT_LATCH so decoding only starts on a word boundary
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= WAIT_LATCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LATCH: begin
                if (!sync2 && (lo_next == LATCH_L)) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (line_rise) begin
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (ev_err) begin
                    state_nxt = WAIT_LATCH;
                end else if (line_fall) begin
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (line_rise) begin
                    state_nxt = HIGH;
                end else if (ev_latch) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = WAIT_LATCH;
        endcase
    end

    // Decode per-state events: malformed pulse, bit shift, latch gap reached
    always_comb begin
        ev_err   = 1'b0;
        ev_shift = 1'b0;
        ev_latch = 1'b0;
        case (state)
            HIGH: begin
                if (line_fall) begin
                    if ((hi_next < min_s) || (hi_next > max_s)) begin
                        ev_err = 1'b1;
                    end else begin
                        ev_shift = 1'b1;
                    end
                end else if (hi_next > max_s) begin
                    ev_err = 1'b1;
                end
            end
            LOW: begin
                if (!line_rise && (lo_next == LATCH_L)) begin
                    ev_latch = 1'b1;
                end
            end
            default: begin
                ev_err   = 1'b0;
                ev_shift = 1'b0;
                ev_latch = 1'b0;
            end
        endcase
    end

    // Mode is only picked up between frames so a frame never mixes bit timings
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            mode_q <= 1'b0;
        end else if ((state == WAIT_LATCH) || (state == IDLE)) begin
            mode_q <= mode;
        end
    end

    // High-time and low-time counters
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            hi_cnt <= 11'd0;
            lo_cnt <= '0;
        end else begin
            case (state)
                WAIT_LATCH: begin
                    hi_cnt <= 11'd0;
                    lo_cnt <= sync2 ? '0 : lo_next;
                end
                IDLE: begin
                    hi_cnt <= 11'd0;
                    lo_cnt <= '0;
                end
                HIGH: begin
                    hi_cnt <= hi_next;
                    lo_cnt <= '0;
                end
                LOW: begin
                    if (line_rise) begin
                        hi_cnt <= 11'd0;
                    end
                    lo_cnt <= lo_next;
                end
                default: begin
                    hi_cnt <= 11'd0;
                    lo_cnt <= '0;
                end
            endcase
        end
    end

    // Assemble the word MSB first; errors and latch gaps throw away a partial word
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            word_sr <= 23'd0;
            bit_cnt <= 5'd0;
        end else if (ev_err || ev_latch) begin
            bit_cnt <= 5'd0;
        end else if (ev_shift) begin
            word_sr <= {word_sr[21:0], bit_val};
            bit_cnt <= word_done ? 5'd0 : bit_cnt + 5'd1;
        end
    end

    // Registered FIFO write, latch strobe and per-frame pixel count
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            dOut        <= 24'd0;
            wr_en       <= 1'b0;
            latch_pulse <= 1'b0;
            pixel_cnt   <= 10'd0;
        end else begin
            wr_en       <= word_done && !full_flg;
            latch_pulse <= ev_latch;
            if (word_done && !full_flg) begin
                dOut <= {word_sr, bit_val};
            end
            if (ev_latch) begin
                pixel_cnt <= 10'd0;
            end else if (word_done && (pixel_cnt != PIX_SAT)) begin
                pixel_cnt <= pixel_cnt + 10'd1;
            end
        end
    end

    // Sticky flags; a set event in the same cycle as clr_flg keeps the flag set
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            err_flg <= 1'b0;
            ovf_flg <= 1'b0;
        end else begin
            if (ev_err || partial_err) begin
                err_flg <= 1'b1;
            end else if (clr_flg) begin
                err_flg <= 1'b0;
            end
            if (word_done && full_flg) begin
                ovf_flg <= 1'b1;
            end else if (clr_flg) begin
                ovf_flg <= 1'b0;
            end
        end
    end

`ifdef NEO_RX_FWD_EN
    logic       fwd_gate;
    logic [1:0] fwd_dly;

    // Open the repeater gate once the first pixel has been consumed (line is low then)
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            fwd_gate <= 1'b0;
        end else if (ev_latch || ev_err) begin
            fwd_gate <= 1'b0;
        end else if (word_done && (pixel_cnt == 10'd0)) begin
            fwd_gate <= 1'b1;
        end
    end

    // Gate at the delay-line input so the tail of the stripped pixel never leaks out
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            fwd_dly     <= 2'b00;
            neo_fwd_out <= 1'b0;
        end else begin
            fwd_dly     <= {fwd_dly[0], sync2 & fwd_gate};
            neo_fwd_out <= fwd_dly[1];
        end
    end
`else
    assign neo_fwd_out = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_neopixel_rx.sv
// tb_neopixel_rx: self-checking bench for neopixel_rx.
// Table-driven single-bit timing records, hand-written multi-cycle sequences and
// randomized frames checked against a pulse-width reference model.

`timescale 1ns/1ps

module tb_neopixel_rx;

    localparam int THRESH = 12;
    localparam int MINH   = 3;
    localparam int MAXH   = 20;
    localparam int LATCH  = 1000;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        mode = 1'b0;
    logic        neo_rx_in = 1'b0;
    logic        full_flg = 1'b0;
    logic        clr_flg = 1'b0;
    logic [23:0] dOut;
    logic        wr_en;
    logic        latch_pulse;
    logic [9:0]  pixel_cnt;
    logic        err_flg;
    logic        ovf_flg;
    logic        neo_fwd_out;

    int checks = 0;
    int errors = 0;

    logic [23:0] obs_q[$];
    logic [23:0] exp_q[$];
    int          latch_cnt = 0;
    int          fwd_rise = 0;
    logic        fwd_prev = 1'b0;

    typedef struct {
        logic m;
        int   hi;
        logic exp_err;
        logic exp_bit;
    } vec_t;

    vec_t vecs[12];

    neopixel_rx dut (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .mode        (mode),
        .neo_rx_in   (neo_rx_in),
        .full_flg    (full_flg),
        .clr_flg     (clr_flg),
        .dOut        (dOut),
        .wr_en       (wr_en),
        .latch_pulse (latch_pulse),
        .pixel_cnt   (pixel_cnt),
        .err_flg     (err_flg),
        .ovf_flg     (ovf_flg),
        .neo_fwd_out (neo_fwd_out)
    );

    // 20 MHz neoClk
    always #25 clk = ~clk;

    // Observe outputs on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (wr_en) obs_q.push_back(dOut);
        if (latch_pulse) latch_cnt++;
        if (neo_fwd_out && !fwd_prev) fwd_rise++;
        fwd_prev = neo_fwd_out;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sc(input int v, input logic m);
        return m ? v * 2 : v;
    endfunction

    task automatic send_bit(input int hi, input int lo);
        neo_rx_in = 1'b1;
        cycles(hi);
        neo_rx_in = 1'b0;
        cycles(lo);
    endtask

    // Nominal timing: 1 = high 16 / low 9, 0 = high 8 / low 17 (doubled in 400 kHz mode)
    task automatic send_nominal(input logic b, input logic m);
        if (b) send_bit(sc(16, m), sc(9, m));
        else   send_bit(sc(8, m), sc(17, m));
    endtask

    task automatic send_word(input logic [23:0] w, input logic m);
        for (int i = 23; i >= 0; i--) send_nominal(w[i], m);
    endtask

    task automatic line_low(input int n);
        neo_rx_in = 1'b0;
        cycles(n);
    endtask

    task automatic pulse_clr();
        clr_flg = 1'b1;
        cycles(1);
        clr_flg = 1'b0;
    endtask

    // Random legal-timing frame; model: a bit is 1 iff its high time >= threshold,
    // words written unless full, all words counted
    task automatic apply_stimulus(input int frame);
        logic        m;
        int          npix;
        logic [23:0] w;
        logic        full;
        logic        exp_ovf;
        int          hi;
        int          base;
        m       = 1'($urandom_range(1, 0));
        npix    = $urandom_range(3, 1);
        exp_ovf = 1'b0;
        exp_q.delete();
        obs_q.delete();
        mode = m;
        pulse_clr();
        cycles(3);
        base = latch_cnt;
        for (int p = 0; p < npix; p++) begin
            w    = 24'($urandom);
            full = ($urandom_range(3, 0) == 0);
            for (int i = 23; i >= 0; i--) begin
                if (i == 11) full_flg = full;
                if (w[i]) hi = $urandom_range(sc(MAXH, m), sc(THRESH, m));
                else      hi = $urandom_range(sc(THRESH, m) - 1, sc(MINH, m));
                send_bit(hi, $urandom_range(20, 4));
            end
            if (full) exp_ovf = 1'b1;
            else      exp_q.push_back(w);
        end
        cycles(8);
        full_flg = 1'b0;
        check_output($sformatf("rand%0d_nwr", frame), obs_q.size(), exp_q.size());
        if (obs_q.size() == exp_q.size()) begin
            for (int k = 0; k < exp_q.size(); k++)
                check_output($sformatf("rand%0d_data%0d", frame, k), obs_q[k], exp_q[k]);
        end
        check_output($sformatf("rand%0d_pixcnt", frame), pixel_cnt, npix);
        check_output($sformatf("rand%0d_ovf", frame), ovf_flg, exp_ovf);
        check_output($sformatf("rand%0d_err", frame), err_flg, 0);
        line_low(1100);
        check_output($sformatf("rand%0d_latch", frame), latch_cnt - base, 1);
        check_output($sformatf("rand%0d_pixclr", frame), pixel_cnt, 0);
    endtask

    initial begin
        logic [23:0] rest;
        logic [23:0] w;
        int          base;

        vecs[0]  = '{1'b0, 11, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 12, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 3,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 20, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 2,  1'b1, 1'b0};
        vecs[5]  = '{1'b0, 21, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 22, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 24, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 6,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 40, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 5,  1'b1, 1'b0};
        vecs[11] = '{1'b1, 41, 1'b1, 1'b0};

        // Reset values
        @(posedge clk);
        #1;
        cycles(5);
        check_output("rst_dout", dOut, 0);
        check_output("rst_strobes", {wr_en, latch_pulse}, 0);
        check_output("rst_pixcnt", pixel_cnt, 0);
        check_output("rst_flags", {err_flg, ovf_flg}, 0);
        check_output("rst_fwd", neo_fwd_out, 0);
        sys_rst = 1'b1;
        line_low(1100);
        check_output("wait_latch_no_pulse", latch_cnt, 0);

        // Basic pixel and latch timing
        obs_q.delete();
        send_word(24'hFF00A5, 1'b0);
        cycles(5);
        check_output("basic_nwr", obs_q.size(), 1);
        if (obs_q.size() == 1) check_output("basic_data", obs_q[0], 24'hFF00A5);
        check_output("basic_pixcnt", pixel_cnt, 1);
        base = latch_cnt;
        cycles(980);
        check_output("latch_not_early", latch_cnt - base, 0);
        cycles(15);
        check_output("latch_on_time", latch_cnt - base, 1);
        check_output("latch_pixclr", pixel_cnt, 0);
        check_output("basic_err", err_flg, 0);
        line_low(200);

        // Table-driven first-bit timing records
        foreach (vecs[v]) begin
            mode = vecs[v].m;
            pulse_clr();
            cycles(3);
            obs_q.delete();
            base = latch_cnt;
            rest = 24'($urandom);
            send_bit(vecs[v].hi, sc(12, vecs[v].m));
            for (int i = 22; i >= 0; i--) send_nominal(rest[i], vecs[v].m);
            cycles(5);
            check_output($sformatf("vec%0d_nwr", v), obs_q.size(), vecs[v].exp_err ? 0 : 1);
            if (!vecs[v].exp_err && obs_q.size() == 1)
                check_output($sformatf("vec%0d_data", v), obs_q[0], {vecs[v].exp_bit, rest[22:0]});
            check_output($sformatf("vec%0d_err", v), err_flg, vecs[v].exp_err);
            line_low(1100);
            check_output($sformatf("vec%0d_latch", v), latch_cnt - base, vecs[v].exp_err ? 0 : 1);
        end
        mode = 1'b0;

        // Partial word at latch
        pulse_clr();
        cycles(3);
        obs_q.delete();
        base = latch_cnt;
        for (int i = 0; i < 10; i++) send_nominal(1'(i % 2), 1'b0);
        line_low(1100);
        check_output("partial_latch", latch_cnt - base, 1);
        check_output("partial_err", err_flg, 1);
        check_output("partial_nwr", obs_q.size(), 0);
        pulse_clr();
        cycles(2);
        check_output("clr_err", err_flg, 0);

        // FIFO full during word completion
        obs_q.delete();
        full_flg = 1'b1;
        send_word(24'h123456, 1'b0);
        cycles(5);
        full_flg = 1'b0;
        check_output("full_nwr", obs_q.size(), 0);
        check_output("full_ovf", ovf_flg, 1);
        check_output("full_pixcnt", pixel_cnt, 1);
        pulse_clr();
        cycles(2);
        check_output("clr_ovf", ovf_flg, 0);
        line_low(1100);

        // 400 kHz two-pixel frame
        mode = 1'b1;
        line_low(20);
        obs_q.delete();
        send_word(24'hC3A50F, 1'b1);
        send_word(24'h5A0F96, 1'b1);
        cycles(5);
        check_output("slow_nwr", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check_output("slow_data0", obs_q[0], 24'hC3A50F);
            check_output("slow_data1", obs_q[1], 24'h5A0F96);
        end
        check_output("slow_pixcnt", pixel_cnt, 2);
        line_low(1100);
        mode = 1'b0;
        line_low(20);

        // Three-pixel frame: repeater forwards only pixels 2 and 3
        obs_q.delete();
        base = fwd_rise;
        send_word(24'h0F0F0F, 1'b0);
        send_word(24'hAAAAAA, 1'b0);
        send_word(24'h000001, 1'b0);
        line_low(1100);
        check_output("three_nwr", obs_q.size(), 3);
`ifdef NEO_RX_FWD_EN
        check_output("fwd_rises", fwd_rise - base, 48);
`else
        check_output("fwd_rises", fwd_rise - base, 0);
`endif

        // Mid-frame attach: reset released during bit 7
        w = 24'hB5E3C7;
        sys_rst = 1'b0;
        cycles(2);
        for (int i = 23; i > 17; i--) send_nominal(w[i], 1'b0);
        neo_rx_in = 1'b1;
        cycles(5);
        sys_rst = 1'b1;
        obs_q.delete();
        base = latch_cnt;
        cycles(11);
        line_low(9);
        for (int i = 16; i >= 0; i--) send_nominal(w[i], 1'b0);
        send_word(24'h3C3C3C, 1'b0);
        cycles(5);
        check_output("attach_no_wr", obs_q.size(), 0);
        line_low(1100);
        check_output("attach_no_latch", latch_cnt - base, 0);
        send_word(w, 1'b0);
        cycles(5);
        check_output("attach_nwr", obs_q.size(), 1);
        if (obs_q.size() == 1) check_output("attach_data", obs_q[0], w);
        line_low(1100);

        // Randomized frames against the reference model
        for (int f = 0; f < 12; f++) apply_stimulus(f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/neopixel_rx.md
# neopixel_rx

Single-wire NeoPixel (WS2812/WS2811) receiver. It sits on the `neoClk` (20 MHz) domain and samples an NRZ pixel stream, the same format the transmitter FSM drives. It decodes each 24-bit pixel word and pushes it into a downstream FIFO_WxD using the same `dataIn`/`wr_en`/`full_flg` handshake. It detects latch (reset) gaps, counts pixels per frame, and flags malformed bits.

## Interface
- `THRESH_CYC`, 12: high-time threshold in clocks (fast mode); a high time ≥ this decodes as 1, below it as 0.
- `MIN_HI_CYC`, 3: shortest legal high pulse (fast mode); anything shorter is a glitch error.
- `MAX_HI_CYC`, 20: longest legal high pulse (fast mode).
- `LATCH_CYC`, 1000: consecutive low clocks that constitute a latch gap (50 µs at 20 MHz). Not scaled by mode.
- `clk` in 1: neoClk, 20 MHz.
- `sys_rst` in 1: asynchronous, active-low reset.
- `mode` in 1: 0 = 800 kHz; 1 = 400 kHz, which doubles `THRESH_CYC`, `MIN_HI_CYC` and `MAX_HI_CYC` (left shift by 1). Sample it only in WAIT_LATCH and IDLE.
- `neo_rx_in` in 1: asynchronous serial line.
- `full_flg` in 1: full flag from the downstream FIFO.
- `clr_flg` in 1: clears the sticky flags.
- `dOut` out 24: decoded pixel. The first received bit lands in bit 23.
- `wr_en` out 1: one-cycle write strobe for `dOut`.
- `latch_pulse` out 1: one-cycle strobe on each detected latch gap.
- `pixel_cnt` out 10: pixels written since the last latch. Saturates at 1023.
- `err_flg` out 1: sticky; set on glitch, over-long high, or partial word at latch.
- `ovf_flg` out 1: sticky; set when a completed word is dropped because the FIFO is full.
- `neo_fwd_out` out 1: repeater output (see Configuration).

## Operation
- `neo_rx_in` passes through a 2-flop synchronizer, then a third flop for edge detection. All decoding uses the synchronized signal.
- State WAIT_LATCH (reset state):
  - Count consecutive low clocks; any high clears the count.
  - On reaching `LATCH_CYC`, go to IDLE with no `latch_pulse`.
  - This guarantees word alignment when attaching to the line mid-frame.
- State IDLE: a rising edge clears `hi_cnt` and moves to HIGH.
- State HIGH:
  - Increment `hi_cnt` (11 bits, saturating).
  - If `hi_cnt` exceeds scaled `MAX_HI_CYC`, set `err_flg`, discard the partial word, and go to WAIT_LATCH.
  - On a falling edge:
    - If `hi_cnt` < scaled `MIN_HI_CYC`, take the same error path as over-long high.
    - Otherwise shift bit (`hi_cnt` ≥ scaled THRESH) into the word and increment `bit_cnt` (0..23).
    - Go to LOW, clearing `lo_cnt`.
- State LOW:
  - Increment `lo_cnt`, saturating at `LATCH_CYC`.
  - A rising edge before `LATCH_CYC` goes to HIGH.
  - When `lo_cnt` reaches `LATCH_CYC`:
    - Pulse `latch_pulse`.
    - If `bit_cnt` ≠ 0, set `err_flg` and discard the partial word.
    - Clear `bit_cnt` and `pixel_cnt`, then go to IDLE.
- Word completion: when the 24th bit shifts in, `bit_cnt` returns to 0.
  - If `full_flg` = 0: assert `wr_en` with `dOut`, and increment `pixel_cnt`.
  - If `full_flg` = 1: no `wr_en`; set `ovf_flg`. `pixel_cnt` still increments, because it counts line pixels.
- `clr_flg` clears both sticky flags. If a set event happens in the same cycle, the set wins.
- An async reset during any state returns to WAIT_LATCH, and the next word starts only after a full latch gap.

## Timing
- Reset values:
  - `dOut` = 0
  - `wr_en` = 0, `latch_pulse` = 0
  - `pixel_cnt` = 0
  - `err_flg` = 0, `ovf_flg` = 0
  - `neo_fwd_out` = 0
  - state WAIT_LATCH
- Input latency: 2 clocks through the synchronizer. Edges are detected on the 3rd register stage.
- `wr_en` and `dOut` are registered. They are valid in the cycle after the synchronized falling edge of bit 24, and `dOut` holds until the next write.
- `latch_pulse` is asserted in the cycle after `lo_cnt` reaches `LATCH_CYC`, measured from the synchronized falling edge of the last bit.
- Bit decision boundary is exact: `hi_cnt` == THRESH decodes as 1, THRESH−1 as 0.
- No back-pressure on the line: `full_flg` never stalls decoding.

## Configuration
- `NEO_RX_FWD_EN` defined:
  - `neo_fwd_out` reproduces the synchronized input, delayed 3 clocks, gated by `fwd_gate`.
  - `fwd_gate` is set at the falling edge of the first pixel's bit 24, while the line is low.
  - `fwd_gate` is cleared on `latch_pulse` or on error.
  - Result: WS2812-style repeater that strips the first pixel.
- Not defined: `neo_fwd_out` is constant 0 and no gating logic is built.

## Test plan
- Fast mode, after a 1000-clock low: send 0xFF00A5 (1-bits high 16 / low 9, 0-bits high 8 / low 17), then a 1000-clock low → one `wr_en` with `dOut` = 0xFF00A5, `pixel_cnt` = 1, then `latch_pulse`, then `pixel_cnt` = 0.
- Threshold edge: high times 11 and 12 clocks → bits 0 and 1. High times 2 and 21 clocks → `err_flg`=1, state WAIT_LATCH, no `wr_en`.
- Partial word: 10 bits then 1000-clock low → `latch_pulse`=1, `err_flg`=1, no `wr_en`.
- `full_flg`=1 during word completion of 0x123456 → no `wr_en`, `ovf_flg`=1, `pixel_cnt` increments. Asserting `clr_flg` → `ovf_flg`=0.
- `mode`=1: high times 22 and 24 clocks → bits 0 and 1. A 2-pixel frame → two writes.
- Mid-frame attach: release reset during bit 7 of a pixel → no `wr_en` until after a 1000-clock low. With `NEO_RX_FWD_EN`: a 3-pixel frame on `neo_fwd_out` carries only pixels 2-3, delayed 3 clocks.
